// File: rtl/aca_var_latency_ctrl.sv
// Variable-latency almost-correct adder: speculative windowed-carry sum with a
// conservative error detector and a segment-serial exact correction fallback.
module aca_var_latency_ctrl #(
  parameter int WIDTH  = 16,
  parameter int WINDOW = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             approx_mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             err_o,
  output logic             corrected_o
);

  localparam int NSEG   = (WIDTH + WINDOW - 1) / WINDOW;
  localparam int KW     = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int LAST_W = WIDTH - (NSEG - 1) * WINDOW;

  typedef enum logic [1:0] {IDLE, EVAL, CORR, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             mode_q;
  logic             c;
  logic [KW-1:0]    k;

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH:0]   ca;
  logic             win_carry;
  logic [WIDTH-1:0] spec_sum;
  logic             spec_cout;
  logic             err_det;

  int               seg_lo;
  logic [WINDOW-1:0] seg_a;
  logic [WINDOW-1:0] seg_b;
  logic [WINDOW:0]  seg_sum;
  logic             seg_cout;
  logic             last_seg;
  logic [WIDTH-1:0] seg_wide;
  logic [WIDTH-1:0] seg_mask;

  assign in_ready_o = (state == IDLE);

  // Each approximate carry ripples only through the WINDOW bits below it.
  always_comb begin
    p         = a_q ^ b_q;
    g         = a_q & b_q;
    ca        = '0;
    win_carry = 1'b0;
    for (int i = 1; i <= WIDTH; i++) begin
      win_carry = 1'b0;
      for (int j = 0; j < WIDTH; j++) begin
        if (j >= i - WINDOW && j < i) begin
          win_carry = g[j] | (p[j] & win_carry);
        end
      end
      ca[i] = win_carry;
    end
    spec_sum  = p ^ ca[WIDTH-1:0];
    spec_cout = ca[WIDTH];
    err_det   = 1'b0;
    for (int j = 0; j <= WIDTH - WINDOW; j++) begin
      if (&p[j +: WINDOW]) begin
        err_det = 1'b1;
      end
    end
  end

  // Slices beyond the top bit read as zero, so a partial last segment's
  // carry-out lands at bit LAST_W of the segment sum instead of bit WINDOW.
  always_comb begin
    seg_lo   = int'(k) * WINDOW;
    seg_a    = WINDOW'(a_q >> seg_lo);
    seg_b    = WINDOW'(b_q >> seg_lo);
    seg_sum  = {1'b0, seg_a} + {1'b0, seg_b} + {{WINDOW{1'b0}}, c};
    last_seg = (k == KW'(NSEG - 1));
    seg_cout = last_seg ? seg_sum[LAST_W] : seg_sum[WINDOW];
    seg_wide = WIDTH'(seg_sum[WINDOW-1:0]) << seg_lo;
    seg_mask = WIDTH'({WINDOW{1'b1}}) << seg_lo;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= 1'b0;
      c           <= 1'b0;
      k           <= '0;
      out_valid_o <= 1'b0;
      sum_o       <= '0;
      cout_o      <= 1'b0;
      err_o       <= 1'b0;
      corrected_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            mode_q <= approx_mode_i;
            state  <= EVAL;
          end
        end
        EVAL: begin
          err_o       <= err_det;
          corrected_o <= 1'b0;
          if (!err_det || mode_q) begin
            sum_o       <= spec_sum;
            cout_o      <= spec_cout;
            out_valid_o <= 1'b1;
            state       <= DONE;
          end else begin
            c     <= 1'b0;
            k     <= '0;
            state <= CORR;
          end
        end
        CORR: begin
          sum_o <= (sum_o & ~seg_mask) | seg_wide;
          c     <= seg_cout;
          if (last_seg) begin
            cout_o      <= seg_cout;
            corrected_o <= 1'b1;
            out_valid_o <= 1'b1;
            k           <= '0;
            state       <= DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aca_var_latency_ctrl.sv
// Bench for aca_var_latency_ctrl: a vector table driven through a scoreboard
// queue, plus backpressure and mid-correction reset sequences.
module tb_aca_var_latency_ctrl;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        mode;
    logic [15:0] sum;
    logic        cout;
    logic        err;
    logic        corr;
    int          lat;
  } vec_t;

  logic        clk_i;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        approx_mode_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] sum_o;
  logic        cout_o;
  logic        err_o;
  logic        corrected_o;

  int   n_checks;
  int   n_fail;
  vec_t vecs[11];
  vec_t sb[$];

  aca_var_latency_ctrl #(.WIDTH(16), .WINDOW(6)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .a_i          (a_i),
    .b_i          (b_i),
    .approx_mode_i(approx_mode_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .sum_o        (sum_o),
    .cout_o       (cout_o),
    .err_o        (err_o),
    .corrected_o  (corrected_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int waited = 0;
    @(negedge clk_i);
    while (!in_ready_o && waited < 10) begin
      @(negedge clk_i);
      waited++;
    end
    checkVal("in_ready_before_accept", 32'(in_ready_o), 32'd1);
    a_i           = v.a;
    b_i           = v.b;
    approx_mode_i = v.mode;
    in_valid_i    = 1'b1;
    @(posedge clk_i);
    sb.push_back(v);
    #1;
    in_valid_i    = 1'b0;
    a_i           = 16'($urandom);
    b_i           = 16'($urandom);
    approx_mode_i = 1'($urandom);
  endtask

  task automatic waitOutput(output int lat);
    lat = 1;
    while (!out_valid_o && lat < 20) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    if (!out_valid_o) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL out_valid_timeout: actual 0, required 1 within 20 edges");
    end
  endtask

  task automatic checkOutput(input string tag, input int lat);
    vec_t exp;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s_scoreboard: actual empty, required one entry", tag);
    end else begin
      exp = sb.pop_front();
      checkVal({tag, "_latency"},   32'(lat),         32'(exp.lat));
      checkVal({tag, "_out_valid"}, 32'(out_valid_o), 32'd1);
      checkVal({tag, "_sum"},       32'(sum_o),       32'(exp.sum));
      checkVal({tag, "_cout"},      32'(cout_o),      32'(exp.cout));
      checkVal({tag, "_err"},       32'(err_o),       32'(exp.err));
      checkVal({tag, "_corrected"}, 32'(corrected_o), 32'(exp.corr));
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkVal({tag, "_out_valid"}, 32'(out_valid_o), 32'd0);
    checkVal({tag, "_in_ready"},  32'(in_ready_o),  32'd1);
    checkVal({tag, "_sum"},       32'(sum_o),       32'd0);
    checkVal({tag, "_cout"},      32'(cout_o),      32'd0);
    checkVal({tag, "_err"},       32'(err_o),       32'd0);
    checkVal({tag, "_corrected"}, 32'(corrected_o), 32'd0);
  endtask

  initial begin
    int lat;
    n_checks = 0;
    n_fail   = 0;

    //               a         b         m     sum       co    err   corr  lat
    vecs[0]  = '{16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0, 2};
    vecs[1]  = '{16'h007F, 16'h0001, 1'b0, 16'h0080, 1'b0, 1'b1, 1'b1, 5};
    vecs[2]  = '{16'h007F, 16'h0001, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 2};
    vecs[3]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 5};
    vecs[4]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 2};
    vecs[5]  = '{16'h00FF, 16'h00FF, 1'b0, 16'h01FE, 1'b0, 1'b0, 1'b0, 2};
    vecs[6]  = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b1, 5};
    vecs[7]  = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 2};
    vecs[8]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 2};
    vecs[9]  = '{16'hFFC0, 16'h0041, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b1, 5};
    vecs[10] = '{16'h8001, 16'h8001, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 2};

    rst_i         = 1'b1;
    in_valid_i    = 1'b0;
    out_ready_i   = 1'b1;
    a_i           = '0;
    b_i           = '0;
    approx_mode_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checkIdleOutputs("reset");
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      waitOutput(lat);
      checkOutput($sformatf("vec%0d", i), lat);
    end

    // Backpressure: outputs must hold while DONE ignores new operands.
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b0;
    applyStimulus(vecs[1]);
    waitOutput(lat);
    checkOutput("bp", lat);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      in_valid_i = ~in_valid_i;
      a_i        = 16'($urandom);
      @(posedge clk_i);
      #1;
      checkVal($sformatf("bp_hold%0d_out_valid", i), 32'(out_valid_o), 32'd1);
      checkVal($sformatf("bp_hold%0d_in_ready", i),  32'(in_ready_o),  32'd0);
      checkVal($sformatf("bp_hold%0d_sum", i),       32'(sum_o),       32'h0080);
      checkVal($sformatf("bp_hold%0d_corrected", i), 32'(corrected_o), 32'd1);
    end
    @(negedge clk_i);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    checkVal("bp_release_out_valid", 32'(out_valid_o), 32'd0);
    checkVal("bp_release_in_ready",  32'(in_ready_o),  32'd1);
    @(posedge clk_i);
    #1;
    checkVal("bp_nothing_accepted", 32'(in_ready_o), 32'd1);

    // Reset lands on the edge ending the second correction cycle.
    applyStimulus(vecs[3]);
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    checkIdleOutputs("midcorr_reset");
    sb.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (6) @(posedge clk_i);
    #1;
    checkVal("midcorr_discarded", 32'(out_valid_o), 32'd0);
    applyStimulus(vecs[0]);
    waitOutput(lat);
    checkOutput("post_reset", lat);
    @(posedge clk_i);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aca_var_latency_ctrl.md
Name: aca_var_latency_ctrl

Overview:
Variable-latency controller for a WIDTH-bit almost-correct adder (ACA).
- Each operand pair first gets a speculative windowed-carry sum. A conservative error detector then checks that sum.
- If an error is flagged, the block sequences a segment-serial exact correction, WINDOW bits per cycle, through one carry register.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 16, operand/sum width
WINDOW, 6, ACA carry-window width and correction segment width; legal range 1..WIDTH
NSEG, ceil(WIDTH/WINDOW) = 3, derived local constant (number of correction segments); not overridable

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
in_valid_i  in  1  operand pair valid
in_ready_o  out  1  controller can accept operands
a_i  in  WIDTH  operand A
b_i  in  WIDTH  operand B
approx_mode_i  in  1  1 = never correct, return speculative result; sampled at accept
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts result
sum_o  out  WIDTH  result sum
cout_o  out  1  result carry-out
err_o  out  1  error detector fired for this operation
corrected_o  out  1  result came from the correction path

Behaviour:
- Definitions (on registered operands A, B):
  - P = A^B, G = A&B.
  - Approximate carry: ca[0]=0. For i in 1..WIDTH, ca[i] = carry out of bit i-1 when rippling bits max(0,i-WINDOW)..i-1 with carry-in 0.
  - Speculative sum bit i = P[i]^ca[i]; speculative cout = ca[WIDTH].
  - err = OR over j=0..WIDTH-WINDOW of (&P[j+WINDOW-1:j]). This is conservative: it may flag cases whose speculative result is already exact.
- States: IDLE, EVAL, CORR, DONE.
- in_ready_o = (state==IDLE). There is no overlap between operations.
- IDLE: when in_valid_i & in_ready_o at an edge, register a_i, b_i, approx_mode_i and go to EVAL.
- EVAL (exactly one cycle):
  - Register err into err_o.
  - If err==0 or mode==1: load speculative sum/cout, corrected_o=0, go to DONE.
  - Else: clear carry register c=0 and segment counter k=0, go to CORR.
- CORR, one cycle per segment k:
  - sum[k*WINDOW +: w] = A+B+c exactly over that slice, where w=min(WINDOW, WIDTH-k*WINDOW).
  - c is updated to the slice carry-out and k increments.
  - After k=NSEG-1: cout_o = c, corrected_o = 1, go to DONE.
  - The last segment may be partial (4 bits at the defaults).
- DONE:
  - out_valid_o=1.
  - sum_o, cout_o, err_o, corrected_o are held stable until out_valid_o & out_ready_i at an edge, then go to IDLE.
  - out_ready_i already high on the first DONE cycle completes the transfer in that cycle.
- Latency, counted in edges from the accept edge to the first cycle out_valid_o is high:
  - No correction: 2.
  - Correction: 2+NSEG (5 at defaults).
  - Minimum spacing between accepts: 3 cycles.
- Reset (synchronous, any state, including mid-CORR):
  - state=IDLE, out_valid_o=0, sum_o=0, cout_o=0, err_o=0, corrected_o=0, c=0, k=0.
  - in_ready_o=1 on the cycle after the reset edge.
  - An in-flight operation is discarded and produces no output.
- in_valid_i outside IDLE is ignored; a_i/b_i changes outside IDLE have no effect.
- Sum wraps modulo 2^WIDTH; the overflow bit is reported only on cout_o.
- WINDOW==WIDTH: the speculative result is exact. The correction path is still taken when err=1 and mode=0, with the same result.

Test Plan:
- Clean add: A=0x0003, B=0x0005, mode=0 -> 2 edges after accept: out_valid=1, sum=0x0008, cout=0, err=0, corrected=0.
- Corrected add: A=0x007F, B=0x0001, mode=0 -> err=1. After 5 edges: sum=0x0080, cout=0, corrected=1. Speculative value 0x0000 is never visible on sum_o.
- Approx mode, same operands (A=0x007F, B=0x0001, mode=1) -> 2 edges: sum=0x0000, err=1, corrected=0.
- Full-width carry: A=0xFFFF, B=0x0001, mode=0 -> err=1, sum=0x0000, cout=1, corrected=1, latency 5.
- Backpressure: hold out_ready_i=0 for 4 cycles in DONE while toggling in_valid_i and a_i -> outputs stable, in_ready_o=0, nothing accepted. Raise out_ready_i -> IDLE next cycle, in_ready_o=1.
- Reset during second CORR cycle of A=0xFFFF, B=0x0001 -> next cycle: out_valid=0, in_ready=1, all outputs 0. A following op A=0x0003, B=0x0005 returns sum=0x0008 normally.
